key_req_gen: RTL and testbench
==============================

# key_req_gen

Parametrised multi-channel request generator for the comb_loop verification environment. Each of `NUM_CH` channels walks a key from 0 to a programmed last key, issuing one request per key and advancing on acknowledge. All outputs are registered, so there is no combinational path from `ack` to `req` or `req_key`. Optional inter-request gap, wrap mode and abort make it the standard stimulus source for downstream responders.

## Interface
- `KEY_W`, 4, key width in bits.
- `NUM_CH`, 2, number of independent request channels (≥1).
- `GAP`, 0, idle cycles with `req` low inserted after each acknowledged request (≥0).

- `clk`  input  1  sole clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `start`  input  1  begin a run on all channels; samples `key_last` and `wrap`.
- `abort`  input  1  synchronous abort; all channels return to IDLE.
- `key_last`  input  KEY_W  final key of a run.
- `wrap`  input  1  1: after `key_last` continue from 0; 0: stop at `key_last`.
- `req`  output  NUM_CH  per-channel request, registered.
- `req_key`  output  NUM_CH×KEY_W  per-channel key, registered, stable while `req` high.
- `ack`  input  NUM_CH  per-channel acknowledge, sampled on the clock edge.
- `busy`  output  1  some channel is in REQ or GAP.
- `done`  output  1  all channels are in DONE.

## Operation
- Per-channel FSM states: IDLE, REQ, GAP, DONE.
- Reset (async): all channels IDLE, `req`=0, `req_key`=0, `busy`=0, `done`=0, config registers 0.
- IDLE/DONE + `start` (and not `abort`): config regs ← `key_last`, `wrap`; each channel key←0, →REQ.
- `start` while `busy`=1 is ignored. `key_last`/`wrap` changes mid-run are ignored.
- REQ + `ack[i]`:
  - Key ≠ last: key ← key+1 (mod 2^KEY_W).
  - Key = last and wrap=1: key ← 0.
  - Key = last and wrap=0: →DONE, `req[i]`←0, key holds last.
  - Otherwise (not DONE): →REQ if GAP=0, else →GAP.
- GAP: `req[i]`=0 for exactly GAP cycles, new key already visible on `req_key[i]`, then →REQ.
- REQ without `ack[i]`: hold `req[i]`=1 and key unchanged indefinitely.
- `ack[i]` while `req[i]`=0 (IDLE/GAP/DONE): ignored.
- `abort`: all channels →IDLE, `req`←0, keys←0. Abort wins over simultaneous `start` and `ack`; no key advance occurs.
- In wrap mode a channel never reaches DONE. Only `abort` or `rst` ends the run.
- Channels advance independently and may be at different keys.
- `key_last`=2^KEY_W−1 with wrap=1 gives natural modular wrap. `key_last`=0 with wrap=0 gives one request per channel.
- `busy` and `done` are decoded from state registers only.

## Timing
- `start` sampled at edge t → `req`=1, `req_key`=0 visible after edge t.
- `ack[i]` sampled high at edge t with `req[i]`=1:
  - GAP=0: next key visible after t, `req[i]` stays 1, so back-to-back acks give one key per cycle.
  - GAP>0: `req[i]`=0 for cycles t..t+GAP−1 (post-edge), 1 again after edge t+GAP.
- Final ack (wrap=0) at edge t: `req[i]`=0 and state DONE after t. `done` rises after the edge at which the last channel finishes.
- Zero combinational input→output paths.
- Async `rst` assertion clears all outputs immediately, regardless of clock. Deassertion is synchronous to `clk` by the environment.

## Structure
- Package `key_req_gen_pkg` holds `ch_state_t` (IDLE, REQ, GAP, DONE).
- Sub-module `key_req_ch` implements one channel: FSM, key counter, gap counter of width $clog2(GAP+1) (min 1). The top instantiates it NUM_CH times via generate.
- The top holds the shared config registers and the `busy`/`done` reductions.

## Test plan
- KEY_W=4, NUM_CH=1, GAP=0, key_last=3, wrap=0, ack tied 1 → keys 0,1,2,3 on consecutive cycles, then `req`=0 and `done`=1 the cycle after key 3 is acked.
- GAP=2, key_last=1, ack pulsed per request → key 0, two cycles `req`=0 showing key 1, key 1 requested, then DONE.
- wrap=1, key_last=15, ack tied 1 for 20 cycles → keys 0..15, 0..3; `done` never asserts; `start` during run ignored.
- NUM_CH=2, ack[0] tied 1, ack[1] only every 3rd cycle, key_last=2 → channels finish at different cycles; `done` only after both; `req_key` on ch1 holds while unacked.
- `abort` together with `ack` and `start` at key 2 → all `req`=0, keys 0, IDLE, no advance. A later `start` restarts at key 0.
- Async `rst` mid-REQ between clock edges → `req`, `req_key`, `busy`, `done` all 0 immediately.

Source files
------------

// File: rtl/key_req_gen_pkg.sv
// key_req_gen_pkg
//   Shared types and helpers for the key_req_gen request generator.
//   ch_state_t : per-channel FSM state encoding (IDLE, REQ, GAP, DONE).
//   gap_cnt_w  : width of the per-channel gap counter for a given GAP.
package key_req_gen_pkg;

    typedef logic [1:0] ch_state_t;

    localparam ch_state_t ST_IDLE = 2'd0;
    localparam ch_state_t ST_REQ  = 2'd1;
    localparam ch_state_t ST_GAP  = 2'd2;
    localparam ch_state_t ST_DONE = 2'd3;

    // A counter must hold values up to GAP-1; never narrower than one bit.
    function automatic int gap_cnt_w(input int gap);
        return (gap > 0) ? $clog2(gap + 1) : 1;
    endfunction

endpackage

// File: rtl/key_req_ch.sv
// key_req_ch
//   One request channel: walks req_key from 0 to cfg_last, one request per
//   key, advancing on ack. Optional GAP idle cycles after each accepted
//   request, optional wrap back to 0 after cfg_last.
// Ports:
//   clk, rst      clock, async active-high reset
//   go            start a run (already qualified by the top: not busy, no abort)
//   abort         synchronous return to IDLE, key cleared
//   cfg_last      final key of the run (held stable by the top during a run)
//   cfg_wrap      1: continue from 0 after cfg_last, 0: stop in DONE
//   ack           acknowledge, only honoured while req is high
//   req, req_key  registered request and key
//   state         FSM state, exported for busy/done decode and debug
module key_req_ch
    import key_req_gen_pkg::*;
#(
    parameter int KEY_W = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [KEY_W-1:0] cfg_last,
    input  logic             cfg_wrap,
    input  logic             ack,
    output logic             req,
    output logic [KEY_W-1:0] req_key,
    output ch_state_t        state
);

    localparam int GW = gap_cnt_w(GAP);
    // Loaded on entry to GAP; GAP reaches REQ after the counter hits zero,
    // giving exactly GAP cycles with req low.
    localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

    logic [GW-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            req     <= 1'b0;
            req_key <= '0;
            gap_cnt <= '0;
        end else if (abort) begin
            state   <= ST_IDLE;
            req     <= 1'b0;
            req_key <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        req_key <= '0;
                        req     <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        if (req_key == cfg_last && !cfg_wrap) begin
                            // Final key accepted: key holds at cfg_last.
                            state <= ST_DONE;
                            req   <= 1'b0;
                        end else begin
                            req_key <= (req_key == cfg_last) ? '0 : req_key + 1'b1;
                            if (GAP == 0) begin
                                state <= ST_REQ;
                                req   <= 1'b1;
                            end else begin
                                state   <= ST_GAP;
                                req     <= 1'b0;
                                gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_REQ;
                        req   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/key_req_gen.sv
// key_req_gen
//   Multi-channel request generator. NUM_CH independent channels each walk
//   a key 0..key_last, issuing one request per key.
// Handshake: req[i]/ack[i] is valid/ready. req[i] and req_key[i] are
//   registered; while req[i] is high the key is held stable until ack[i] is
//   sampled high on a rising edge, which is the single transfer event.
//   ack[i] while req[i] is low has no effect. No path from ack to req exists.
// Ports:
//   clk, rst     clock, async active-high reset
//   start        begin a run on all channels (ignored while busy)
//   abort        synchronous abort to IDLE, wins over start and ack
//   key_last     final key, sampled on an accepted start
//   wrap         wrap mode, sampled on an accepted start
//   req, req_key per-channel request and key (key i at [i*KEY_W +: KEY_W])
//   ack          per-channel acknowledge
//   busy         some channel in REQ or GAP
//   done         every channel in DONE
//   state_dbg    per-channel FSM state (channel i at [2*i +: 2])
module key_req_gen
    import key_req_gen_pkg::*;
#(
    parameter int KEY_W  = 4,
    parameter int NUM_CH = 2,
    parameter int GAP    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [KEY_W-1:0]        key_last,
    input  logic                    wrap,
    output logic [NUM_CH-1:0]       req,
    output logic [NUM_CH*KEY_W-1:0] req_key,
    input  logic [NUM_CH-1:0]       ack,
    output logic                    busy,
    output logic                    done,
    output logic [2*NUM_CH-1:0]     state_dbg
);

    logic [KEY_W-1:0] cfg_last;
    logic             cfg_wrap;
    logic             go;
    ch_state_t        ch_state [NUM_CH];

    // A run can only start when no channel is mid-run; abort always wins.
    assign go = start && !abort && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_last <= '0;
            cfg_wrap <= 1'b0;
        end else if (go) begin
            cfg_last <= key_last;
            cfg_wrap <= wrap;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        key_req_ch #(
            .KEY_W (KEY_W),
            .GAP   (GAP)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .go       (go),
            .abort    (abort),
            .cfg_last (cfg_last),
            .cfg_wrap (cfg_wrap),
            .ack      (ack[i]),
            .req      (req[i]),
            .req_key  (req_key[i*KEY_W +: KEY_W]),
            .state    (ch_state[i])
        );
        assign state_dbg[2*i +: 2] = ch_state[i];
    end

    // Decoded from state registers only.
    always_comb begin
        busy = 1'b0;
        done = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            busy = busy | (ch_state[i] == ST_REQ) | (ch_state[i] == ST_GAP);
            done = done & (ch_state[i] == ST_DONE);
        end
    end

endmodule

// File: tb/tb_key_req_gen.sv
module tb_key_req_gen;

    logic       clk;
    logic       rst;

    // DUT A: two channels, no gap
    logic       start_a, abort_a, wrap_a;
    logic [3:0] key_last_a;
    logic [1:0] req_a, ack_a;
    logic [7:0] req_key_a;
    logic       busy_a, done_a;
    logic [3:0] state_a;

    // DUT B: one channel, GAP=2
    logic       start_b, abort_b, wrap_b;
    logic [3:0] key_last_b;
    logic [0:0] req_b, ack_b;
    logic [3:0] req_key_b;
    logic       busy_b, done_b;
    logic [1:0] state_b;

    int n_assert = 0;
    int n_fail   = 0;

    logic [3:0] exp_q0[$];
    logic [3:0] exp_q1[$];
    logic [3:0] exp_qb[$];

    logic [1:0] hold_a;
    logic [3:0] prev_key_a [2];
    logic       done_seen;
    logic       saw_split;

    key_req_gen #(.KEY_W(4), .NUM_CH(2), .GAP(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .key_last(key_last_a), .wrap(wrap_a), .req(req_a), .req_key(req_key_a),
        .ack(ack_a), .busy(busy_a), .done(done_a), .state_dbg(state_a)
    );

    key_req_gen #(.KEY_W(4), .NUM_CH(1), .GAP(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .key_last(key_last_b), .wrap(wrap_b), .req(req_b), .req_key(req_key_b),
        .ack(ack_b), .busy(busy_b), .done(done_b), .state_dbg(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input int ch, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            logic [3:0] kv;
            kv = 4'(k);
            if (ch == 0) exp_q0.push_back(kv);
            else if (ch == 1) exp_q1.push_back(kv);
            else exp_qb.push_back(kv);
        end
    endtask

    task automatic pop_cmp(input int ch, input logic [3:0] got);
        if (ch == 0) begin
            if (exp_q0.size() == 0) check("a0_unexpected_req", exp_q0.size(), 1);
            else check("a0_key", got, exp_q0.pop_front());
        end else if (ch == 1) begin
            if (exp_q1.size() == 0) check("a1_unexpected_req", exp_q1.size(), 1);
            else check("a1_key", got, exp_q1.pop_front());
        end else begin
            if (exp_qb.size() == 0) check("b_unexpected_req", exp_qb.size(), 1);
            else check("b_key", got, exp_qb.pop_front());
        end
    endtask

    // Scoreboard monitor: sampled mid-cycle; a req&ack seen here is the
    // transfer that happens at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold_a = 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (hold_a[i])
                    check("a_hold", {req_a[i], req_key_a[i*4 +: 4]}, {1'b1, prev_key_a[i]});
                if (req_a[i] && ack_a[i] && !abort_a)
                    pop_cmp(i, req_key_a[i*4 +: 4]);
                hold_a[i]     = req_a[i] && !ack_a[i] && !abort_a;
                prev_key_a[i] = req_key_a[i*4 +: 4];
            end
            if (req_b[0] && ack_b[0] && !abort_b)
                pop_cmp(2, req_key_b);
        end
    end

    logic [0:4] gap_req  = 5'b10010;
    logic [3:0] gap_key [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
    logic [0:4] gap_done = 5'b00001;

    initial begin
        rst = 1'b1;
        hold_a = 2'b00;
        start_a = 0; abort_a = 0; wrap_a = 0; key_last_a = 0; ack_a = 0;
        start_b = 0; abort_b = 0; wrap_b = 0; key_last_b = 0; ack_b = 0;
        done_seen = 0; saw_split = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", req_a, 0);
        check("rst_key", req_key_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_state", state_a, 0);
        rst = 1'b0;
        step();

        // Back-to-back run, key_last=3, ack tied high
        key_last_a = 4'd3; wrap_a = 0; ack_a = 2'b11; start_a = 1;
        push_run(0, 0, 3); push_run(1, 0, 3);
        step();
        start_a = 0;
        check("t1_start_req", req_a, 2'b11);
        check("t1_start_key", req_key_a, 8'h00);
        check("t1_busy", busy_a, 1);
        for (int k = 1; k <= 3; k++) begin
            logic [3:0] kv;
            step();
            kv = 4'(k);
            check("t1_key", req_key_a, {kv, kv});
            check("t1_not_done", done_a, 0);
        end
        step();
        check("t1_done", done_a, 1);
        check("t1_req_low", req_a, 0);
        check("t1_busy_low", busy_a, 0);
        check("t1_key_hold", req_key_a, 8'h33);
        check("t1_state", state_a, 4'hF);
        step();
        check("t1_ack_in_done", req_a, 0);
        ack_a = 2'b00;

        // Independent channels: ch1 acked every third cycle
        key_last_a = 4'd2; start_a = 1; ack_a = 2'b01;
        push_run(0, 0, 2); push_run(1, 0, 2);
        step();
        start_a = 0;
        for (int c = 0; c < 40 && !done_a; c++) begin
            ack_a[1] = (c % 3 == 2);
            step();
            if (state_a[1:0] == 2'd3 && state_a[3:2] != 2'd3) begin
                saw_split = 1;
                check("t4_done_early", done_a, 0);
            end
        end
        check("t4_done", done_a, 1);
        check("t4_split", saw_split, 1);
        ack_a = 2'b00;

        // Wrap run, key_last=15, 20 acks, mid-run start/config change ignored
        key_last_a = 4'd15; wrap_a = 1; start_a = 1; ack_a = 2'b11;
        push_run(0, 0, 15); push_run(0, 0, 3);
        push_run(1, 0, 15); push_run(1, 0, 3);
        step();
        start_a = 0;
        for (int s = 1; s <= 20; s++) begin
            if (s == 10) begin
                start_a = 1; key_last_a = 4'd2; wrap_a = 0;
            end
            step();
            start_a = 0;
            done_seen = done_seen | done_a;
        end
        ack_a = 2'b00;
        check("wrap_no_done", done_seen, 0);
        check("wrap_key", req_key_a, 8'h44);
        check("wrap_req", req_a, 2'b11);
        abort_a = 1;
        step();
        abort_a = 0;
        check("wrap_abort_state", state_a, 0);

        // Abort together with start and ack at key 2
        key_last_a = 4'd5; wrap_a = 0; start_a = 1; ack_a = 2'b11;
        push_run(0, 0, 5); push_run(1, 0, 5);
        step();
        start_a = 0;
        step();
        step();
        check("ab_pre_key", req_key_a, 8'h22);
        abort_a = 1; start_a = 1; ack_a = 2'b11;
        exp_q0.delete(); exp_q1.delete();
        step();
        abort_a = 0; start_a = 0; ack_a = 2'b00;
        check("ab_req", req_a, 0);
        check("ab_key", req_key_a, 8'h00);
        check("ab_state", state_a, 0);
        check("ab_busy", busy_a, 0);
        step();
        check("ab_still_idle", state_a, 0);
        key_last_a = 4'd0; start_a = 1;
        push_run(0, 0, 0); push_run(1, 0, 0);
        step();
        start_a = 0;
        check("restart_req", req_a, 2'b11);
        check("restart_key", req_key_a, 8'h00);
        ack_a = 2'b11;
        step();
        ack_a = 2'b00;
        check("single_done", done_a, 1);
        check("single_req", req_a, 0);

        // GAP=2, key_last=1, ack held high (ignored during GAP)
        key_last_b = 4'd1; wrap_b = 0; ack_b = 1'b1; start_b = 1;
        push_run(2, 0, 1);
        step();
        start_b = 0;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) step();
            check("gap_req", req_b, gap_req[s]);
            check("gap_key", req_key_b, gap_key[s]);
            check("gap_done", done_b, gap_done[s]);
        end
        ack_b = 1'b0;

        // Async reset between edges during REQ
        key_last_a = 4'd7; start_a = 1; ack_a = 2'b00;
        step();
        start_a = 0;
        step();
        check("ar_pre_busy", busy_a, 1);
        #1 rst = 1'b1;
        #1;
        check("ar_req", req_a, 0);
        check("ar_key", req_key_a, 0);
        check("ar_busy", busy_a, 0);
        check("ar_done", done_a, 0);
        check("ar_done_b", done_b, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("ar_state", state_a, 0);
        step();

        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);
        check("qb_empty", exp_qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got %0d assertions expected completion", n_assert);
        $fatal(1, "timeout");
    end

endmodule
